// File: rtl/qdec_cabac_package.sv
// rtl/qdec_cabac_package.sv - shared types and constants for the CABAC bitstream front end
package qdec_cabac_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_bs_fetch_state_e;

    localparam logic [7:0] EPB_BYTE    = 8'h03;
    localparam int         BS_ZERO_RUN = 2;

endpackage

// File: rtl/qdec_sync_fifo.sv
// rtl/qdec_sync_fifo.sv - single-clock FIFO, read data shows the head entry, pointers advance on the clock
module qdec_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_i) wptr_q <= wptr_q + AW'(1);
            if (rd_en_i) rptr_q <= rptr_q + AW'(1);
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/qdec_bs_fetch.sv
// rtl/qdec_bs_fetch.sv - NAL payload fetcher with emulation-prevention byte removal
// Optional epb_cnt output enabled by QDEC_BS_EPB_CNT_EN.
module qdec_bs_fetch
    import qdec_cabac_package::*;
#(
    parameter int ADDR_W     = 20,
    parameter int LEN_W      = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        bitstreamFetch,
    output logic              bitstreamFetch_vld,
    input  logic              bitstreamFetch_rdy
`ifdef QDEC_BS_EPB_CNT_EN
    ,
    output logic [LEN_W-1:0]  epb_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    t_bs_fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;
    logic              inflight_q;
    logic [1:0]        zero_cnt_q, zero_cnt_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;

    logic [7:0]        fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [CW:0]       credit;
    logic              accept_start, issue, pop, drop;

    qdec_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (inflight_q),
        .wr_data_i (mem_rdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty)
    );

    // The read in flight already owns a FIFO slot, so it counts against the credit.
    assign credit       = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
    assign accept_start = (state_q == IDLE) && start;
    assign issue        = (state_q == FETCH) && (rd_left_q != '0) &&
                          (credit < (CW+1)'(FIFO_DEPTH));
    assign pop          = !fifo_empty && (!out_vld_q || bitstreamFetch_rdy);
    assign drop         = pop && (zero_cnt_q == 2'(BS_ZERO_RUN)) && (fifo_rdata == EPB_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (byte_len == '0) ? DONE : FETCH;
            FETCH:   if (rd_left_d == '0) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !inflight_q && !out_vld_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        mem_re = issue;
    end

    always_comb begin
        rd_addr_d = rd_addr_q;
        rd_left_d = rd_left_q;
        if (accept_start) begin
            rd_addr_d = base_addr;
            rd_left_d = byte_len;
        end else if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_left_d = rd_left_q - LEN_W'(1);
        end
    end

    // A dropped 0x03 uses its pop slot but never reaches the output register.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q && !bitstreamFetch_rdy;
        if (accept_start) begin
            zero_cnt_d = '0;
        end else if (drop) begin
            zero_cnt_d = '0;
        end else if (pop) begin
            out_data_d = fifo_rdata;
            out_vld_d  = 1'b1;
            if (fifo_rdata != 8'h00)                     zero_cnt_d = '0;
            else if (zero_cnt_q != 2'(BS_ZERO_RUN))      zero_cnt_d = zero_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            inflight_q <= 1'b0;
            zero_cnt_q <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            rd_left_q  <= rd_left_d;
            inflight_q <= issue;
            zero_cnt_q <= zero_cnt_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign mem_raddr          = rd_addr_q;
    assign bitstreamFetch     = out_data_q;
    assign bitstreamFetch_vld = out_vld_q;

`ifdef QDEC_BS_EPB_CNT_EN
    logic [LEN_W-1:0] epb_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         epb_cnt_q <= '0;
        else if (accept_start)              epb_cnt_q <= '0;
        else if (drop && (epb_cnt_q != '1)) epb_cnt_q <= epb_cnt_q + LEN_W'(1);
    end

    assign epb_cnt = epb_cnt_q;
`endif

endmodule

// File: tb/tb_qdec_bs_fetch.sv
// tb/tb_qdec_bs_fetch.sv - self-checking bench for qdec_bs_fetch (directed table plus randomized runs)
module tb_qdec_bs_fetch;

    localparam int ADDR_W = 20;
    localparam int LEN_W  = 20;
    localparam int DEPTH  = 8;

    typedef logic [7:0] byte_q [$];
    typedef int         int_q  [$];

    typedef struct {
        int         len;
        logic [7:0] raw [8];
        int         exp_n;
        logic [7:0] exp [8];
        int         exp_epb;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  byte_len = '0;
    logic              busy, done, mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata = '0;
    logic [7:0]        bitstreamFetch;
    logic              bitstreamFetch_vld;
    logic              bitstreamFetch_rdy = 1'b1;
`ifdef QDEC_BS_EPB_CNT_EN
    logic [LEN_W-1:0]  epb_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] ram [logic [ADDR_W-1:0]];

    qdec_bs_fetch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_addr          (base_addr),
        .byte_len           (byte_len),
        .busy               (busy),
        .done               (done),
        .mem_raddr          (mem_raddr),
        .mem_re             (mem_re),
        .mem_rdata          (mem_rdata),
        .bitstreamFetch     (bitstreamFetch),
        .bitstreamFetch_vld (bitstreamFetch_vld),
        .bitstreamFetch_rdy (bitstreamFetch_rdy)
`ifdef QDEC_BS_EPB_CNT_EN
        ,
        .epb_cnt            (epb_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the read enable, junk otherwise.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram.exists(mem_raddr) ? ram[mem_raddr] : 8'h00;
        else        mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Emulation prevention: a 0x03 following two or more zero bytes is removed,
    // and the zero run restarts after the removed byte.
    function automatic void ref_model(input byte_q raw, output byte_q outq,
                                      output int_q rawidx, output int nd);
        int zeros = 0;
        outq = {};
        rawidx = {};
        nd = 0;
        foreach (raw[i]) begin
            if (zeros >= 2 && raw[i] == 8'h03) begin
                nd++;
                zeros = 0;
            end else begin
                outq.push_back(raw[i]);
                rawidx.push_back(i);
                zeros = (raw[i] == 8'h00) ? zeros + 1 : 0;
            end
        end
    endfunction

    task automatic run_test(input logic [ADDR_W-1:0] base, input byte_q raw,
                            input byte_q exp, input int exp_epb, input int rmode);
        byte_q mdl_out;
        int_q  rawidx;
        int    mdl_epb;
        int    idx = 0, issued = 0, cyc = 0, consumed = 0;
        int    first_re = -1, first_v = -1, first_x = -1, last_x = -1, done_cyc = -1;
        bit    done_seen = 0, prev_stall = 0, addr_ok = 1, hold_ok = 1, credit_ok = 1;
        logic  [7:0] prev_data = '0;
        logic  r;

        ref_model(raw, mdl_out, rawidx, mdl_epb);
        foreach (raw[i]) ram[ADDR_W'(base + ADDR_W'(i))] = raw[i];

        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        byte_len = LEN_W'(raw.size());
        @(negedge clk);
        start = 1'b0;
        base_addr = '0;
        byte_len = '0;

        while (!done_seen && cyc < 3000) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bitstreamFetch_rdy = r;
            if (prev_stall && (!bitstreamFetch_vld || bitstreamFetch != prev_data)) hold_ok = 0;
            if (mem_re) begin
                if (mem_raddr != ADDR_W'(base + ADDR_W'(issued))) addr_ok = 0;
                if (first_re < 0) first_re = cyc;
                issued++;
                if (issued - consumed > DEPTH + 2) credit_ok = 0;
            end
            if (bitstreamFetch_vld && first_v < 0) first_v = cyc;
            if (bitstreamFetch_vld && r) begin
                if (idx < exp.size()) chk($sformatf("data[%0d]", idx), bitstreamFetch, exp[idx]);
                else                  chk("extra_byte", 1, 0);
                if (idx < rawidx.size()) consumed = rawidx[idx] + 1;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                idx++;
            end
            prev_stall = bitstreamFetch_vld && !r;
            prev_data  = bitstreamFetch;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            cyc++;
            @(negedge clk);
        end

        chk("done_seen", done_seen, 1);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("vld_after_done", bitstreamFetch_vld, 0);
        chk("byte_count", idx, exp.size());
        chk("reads_issued", issued, raw.size());
        chk("read_addr_seq", addr_ok, 1);
        chk("hold_under_stall", hold_ok, 1);
        chk("credit_bound", credit_ok, 1);
        if (raw.size() == 0) chk("empty_done_cycle", done_cyc, 0);
        else                 chk("first_latency", first_v - first_re, 3);
        if (rmode == 0 && exp_epb == 0 && exp.size() > 0)
            chk("throughput", last_x - first_x, exp.size() - 1);
`ifdef QDEC_BS_EPB_CNT_EN
        chk("epb_cnt", epb_cnt, exp_epb);
`endif
        bitstreamFetch_rdy = 1'b1;
    endtask

    initial begin
        vec_t  tbl [4];
        byte_q raw, exp, mq;
        int_q  ri;
        int    nd, n;

        tbl[0] = '{len: 6, raw: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00},
                   exp_n: 6, exp: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00}, exp_epb: 0};
        tbl[1] = '{len: 8, raw: '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03},
                   exp_n: 6, exp: '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00}, exp_epb: 2};
        tbl[2] = '{len: 5, raw: '{8'h00, 8'h00, 8'h00, 8'h03, 8'h7F, 8'h00, 8'h00, 8'h00},
                   exp_n: 4, exp: '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00}, exp_epb: 1};
        tbl[3] = '{len: 6, raw: '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00},
                   exp_n: 4, exp: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, exp_epb: 2};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_data", bitstreamFetch, 0);
        chk("rst_vld", bitstreamFetch_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            raw = {};
            exp = {};
            for (int i = 0; i < tbl[t].len; i++)   raw.push_back(tbl[t].raw[i]);
            for (int i = 0; i < tbl[t].exp_n; i++) exp.push_back(tbl[t].exp[i]);
            run_test(ADDR_W'(20'h100 + t * 20'h40), raw, exp, tbl[t].exp_epb, 0);
        end

        raw = {};
        exp = {};
        run_test(ADDR_W'(20'h200), raw, exp, 0, 0);

        for (int k = 0; k < 14; k++) begin
            logic [ADDR_W-1:0] base;
            int len, mode;
            raw  = {};
            len  = (k == 0) ? 20 : $urandom_range(1, 40);
            mode = (k == 0) ? 1 : k % 3;
            base = (k % 3 == 0) ? ADDR_W'(20'hFFFFF - $urandom_range(0, 5)) : ADDR_W'($urandom);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0, 1:    raw.push_back(8'h00);
                    2:       raw.push_back(8'h03);
                    default: raw.push_back(8'($urandom));
                endcase
            end
            ref_model(raw, mq, ri, nd);
            run_test(base, raw, mq, nd, mode);
        end

        // Reset in the middle of a fetch, then a fresh short payload.
        raw = {};
        for (int i = 0; i < 20; i++) begin
            raw.push_back(8'(i + 1));
            ram[ADDR_W'(20'h3000 + i)] = 8'(i + 1);
        end
        @(negedge clk);
        start = 1'b1;
        base_addr = ADDR_W'(20'h3000);
        byte_len = LEN_W'(20);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (mem_re) n++;
            if (n == 5) break;
            @(negedge clk);
        end
        chk("mid_fetch_reached", n, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_mem_re", mem_re, 0);
        chk("async_rst_mem_raddr", mem_raddr, 0);
        chk("async_rst_data", bitstreamFetch, 0);
        chk("async_rst_vld", bitstreamFetch_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        raw = '{8'hA5, 8'h00, 8'h5A};
        run_test(ADDR_W'(20'h4000), raw, raw, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
